// File: rtl/multi_bank_bram_stream_reader.sv
// Purpose: reads a burst from all BRAM banks in lock-step and packs the per-bank words into AXI-Stream beats.
// Latency: first beat is valid 2 cycles after command acceptance; sustains 1 beat/cycle with tready high.
// Backpressure: credit-based issue (FIFO occupancy + in-flight read < 3) from registered state only; never depends on m_axis_tready.
module multi_bank_bram_stream_reader #(
    parameter int BANKS      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         cmd_addr,
    input  logic [ADDR_WIDTH-1:0]         cmd_len,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    output logic [BANKS-1:0]              bram_rden,
    output logic [BANKS*ADDR_WIDTH-1:0]   bram_addr,
    input  logic [BANKS*DATA_WIDTH-1:0]   bram_dout,
    output logic [BANKS*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy
);

    localparam int BEAT_W = BANKS * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
    logic [ADDR_WIDTH-1:0]   bram_addr_q, bram_addr_d;
    logic                    inflight_q, inflight_d;
    logic                    inflight_last_q, inflight_last_d;

    // Three-entry output FIFO; storage has a fourth slot so a 2-bit pointer
    // always indexes in range, but pointers wrap after slot 2.
    logic [BEAT_W-1:0]       mem_dat_q [4];
    logic [BEAT_W-1:0]       mem_dat_d [4];
    logic [3:0]              mem_last_q, mem_last_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [1:0]              occ_q, occ_d;

    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   cur_addr;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue/capture/pop decisions and next-state logic for FSM, counters and FIFO.
    always_comb begin
        issue           = (state_q == S_READ) && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
        push            = inflight_q;
        pop             = (occ_q != 2'd0) && m_axis_tready;

        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == '0);
        bram_addr_d     = issue ? addr_q : bram_addr_q;
        cur_addr        = bram_addr_d;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - ADDR_WIDTH'(1);
                    if (rem_q == '0) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_dat_d  = mem_dat_q;
        mem_last_d = mem_last_q;
        if (push) begin
            mem_dat_d[wr_ptr_q]  = bram_dout;
            mem_last_d[wr_ptr_q] = inflight_last_q;
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state register with synchronous reset; discards any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            bram_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            wr_ptr_q        <= 2'd0;
            rd_ptr_q        <= 2'd0;
            occ_q           <= 2'd0;
            mem_last_q      <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            bram_addr_q     <= bram_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            mem_last_q      <= mem_last_d;
        end
    end

    // FIFO data storage; contents are qualified by occupancy, so no reset needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            mem_dat_q[i] <= mem_dat_d[i];
        end
    end

    assign cmd_ready     = (state_q == S_IDLE) && !rst;
    assign bram_rden     = {BANKS{issue}};
    assign bram_addr     = {BANKS{cur_addr}};
    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = mem_dat_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid && mem_last_q[rd_ptr_q];
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_bank_bram_stream_reader.sv
// Bench for multi_bank_bram_stream_reader: BRAM model where bank i at address a holds {i, a}.
// Expected beats are queued when each command is driven and compared as beats are collected.
// Each scenario task checks its own results inline.
module tb_multi_bank_bram_stream_reader;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   cmd_addr;
    logic [15:0]   cmd_len;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    bram_rden;
    logic [63:0]   bram_addr;
    logic [127:0]  bram_dout;
    logic [127:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rden_cnt = 0;
    int lock_err = 0;

    logic [127:0] exp_dat[$];
    bit           exp_last[$];
    logic [127:0] got_dat[$];
    bit           got_last[$];
    int           got_cyc[$];
    int           acc_q[$];
    logic [15:0]  addr_log[$];

    multi_bank_bram_stream_reader #(
        .BANKS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .bram_rden(bram_rden), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle id: value seen at a negedge labels the following posedge.
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model with 1-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bram_rden[i]) bram_dout[i*32 +: 32] <= {16'(i), bram_addr[i*16 +: 16]};
        end
    end

    // Records command accepts, read issues and lock-step violations.
    always @(posedge clk) begin
        if (!rst && cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (bram_rden != 4'h0) begin
            rden_cnt++;
            addr_log.push_back(bram_addr[15:0]);
            if (bram_rden != 4'hF || bram_addr != {4{bram_addr[15:0]}}) lock_err++;
        end
    end

    function automatic logic [127:0] word(input logic [15:0] a);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) w[i*32 +: 32] = {16'(i), a};
        return w;
    endfunction

    task automatic push_exp(input logic [15:0] a, input logic [15:0] len);
        for (int k = 0; k <= int'(len); k++) begin
            exp_dat.push_back(word(a + 16'(k)));
            exp_last.push_back(k == int'(len));
        end
    endtask

    task automatic issue_cmd(input logic [15:0] a, input logic [15:0] len);
        @(negedge clk);
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        push_exp(a, len);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Collects up to n beats within budget cycles; tready random or held high.
    task automatic collect(input int n, input int budget, input bit rnd);
        got_dat.delete(); got_last.delete(); got_cyc.delete();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                got_dat.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                got_cyc.push_back(cyc);
                if (got_dat.size() == n) break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready_high: got %b want 0", cmd_ready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) $display("FAIL rst_tvalid_tlast: got %b%b want 00", m_axis_tvalid, m_axis_tlast); else n_pass++;
        n_checks++; if (busy !== 1'b0 || bram_rden !== 4'h0) $display("FAIL rst_busy_rden: got %b/%h want 0/0", busy, bram_rden); else n_pass++;
        n_checks++; if (bram_addr !== 64'h0) $display("FAIL rst_bram_addr: got %h want 0", bram_addr); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
    endtask

    task automatic test_basic_burst();
        int a0;
        acc_q.delete(); exp_dat.delete(); exp_last.delete();
        m_axis_tready = 1'b1;
        issue_cmd(16'h0010, 16'd3);
        collect(4, 50, 1'b0);
        n_checks++; if (got_dat.size() != 4) $display("FAIL basic_count: got %0d want 4", got_dat.size()); else n_pass++;
        for (int k = 0; k < got_dat.size(); k++) begin
            n_checks++;
            if (got_dat[k] !== exp_dat[0] || got_last[k] !== exp_last[0]) $display("FAIL basic_beat%0d: got %h/%b want %h/%b", k, got_dat[k], got_last[k], exp_dat[0], exp_last[0]); else n_pass++;
            void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
        a0 = (acc_q.size() > 0) ? acc_q[0] : -100;
        if (got_cyc.size() == 4) begin
            n_checks++; if (got_cyc[0] != a0 + 3) $display("FAIL basic_first_latency: got %0d want %0d", got_cyc[0] - a0, 3); else n_pass++;
            n_checks++; if (got_cyc[3] != got_cyc[0] + 3) $display("FAIL basic_consecutive: got span %0d want 3", got_cyc[3] - got_cyc[0]); else n_pass++;
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_after_pop: got %b want 1", busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_word();
        rden_cnt = 0; exp_dat.delete(); exp_last.delete();
        m_axis_tready = 1'b1;
        issue_cmd(16'h0005, 16'd0);
        collect(1, 30, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (rden_cnt != 1) $display("FAIL single_rden_pulses: got %0d want 1", rden_cnt); else n_pass++;
        n_checks++;
        if (got_dat.size() != 1 || got_dat[0] !== word(16'h0005) || got_last[0] !== 1'b1) $display("FAIL single_beat: got n=%0d want one beat %h with tlast", got_dat.size(), word(16'h0005)); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1 || m_axis_tvalid !== 1'b0) $display("FAIL single_idle: got ready=%b tvalid=%b want 1/0", cmd_ready, m_axis_tvalid); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [15:0] want_a [4];
        want_a[0] = 16'hFFFE; want_a[1] = 16'hFFFF; want_a[2] = 16'h0000; want_a[3] = 16'h0001;
        addr_log.delete(); exp_dat.delete(); exp_last.delete();
        issue_cmd(16'hFFFE, 16'd3);
        collect(4, 50, 1'b0);
        n_checks++; if (addr_log.size() != 4) $display("FAIL wrap_issue_count: got %0d want 4", addr_log.size()); else n_pass++;
        for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
            n_checks++; if (addr_log[k] !== want_a[k]) $display("FAIL wrap_addr%0d: got %h want %h", k, addr_log[k], want_a[k]); else n_pass++;
        end
        n_checks++; if (got_dat.size() != 4) $display("FAIL wrap_count: got %0d want 4", got_dat.size()); else n_pass++;
        for (int k = 0; k < got_dat.size(); k++) begin
            n_checks++;
            if (got_dat[k] !== exp_dat[0] || got_last[k] !== exp_last[0]) $display("FAIL wrap_beat%0d: got %h want %h", k, got_dat[k], exp_dat[0]); else n_pass++;
            void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
    endtask

    task automatic test_backpressure();
        bit           seen = 1'b0;
        int           stab_err = 0;
        logic [127:0] first = '0;
        rden_cnt = 0; exp_dat.delete(); exp_last.delete();
        @(negedge clk);
        m_axis_tready = 1'b0;
        issue_cmd(16'h0300, 16'd15);
        repeat (10) begin
            @(negedge clk); #1;
            if (seen && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== first)) stab_err++;
            if (m_axis_tvalid && !seen) begin seen = 1'b1; first = m_axis_tdata; end
        end
        n_checks++; if (rden_cnt != 3) $display("FAIL bp_rden_pulses: got %0d want 3", rden_cnt); else n_pass++;
        n_checks++; if (!seen || first !== exp_dat[0]) $display("FAIL bp_head_beat: got %h want %h", first, exp_dat[0]); else n_pass++;
        n_checks++; if (stab_err != 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err); else n_pass++;
        collect(16, 600, 1'b1);
        n_checks++; if (got_dat.size() != 16) $display("FAIL bp_count: got %0d want 16", got_dat.size()); else n_pass++;
        for (int k = 0; k < got_dat.size(); k++) begin
            n_checks++;
            if (got_dat[k] !== exp_dat[0] || got_last[k] !== exp_last[0]) $display("FAIL bp_beat%0d: got %h/%b want %h/%b", k, got_dat[k], got_last[k], exp_dat[0], exp_last[0]); else n_pass++;
            void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
        repeat (4) @(negedge clk);
        n_checks++; if (rden_cnt != 16) $display("FAIL bp_total_reads: got %0d want 16", rden_cnt); else n_pass++;
        n_checks++; if (lock_err != 0) $display("FAIL lockstep: got %0d violations want 0", lock_err); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        exp_dat.delete(); exp_last.delete();
        m_axis_tready = 1'b0;
        issue_cmd(16'h0200, 16'd15);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0 || bram_rden !== 4'h0 || busy !== 1'b0 || m_axis_tlast !== 1'b0) $display("FAIL midrst_state: got tvalid=%b rden=%h busy=%b tlast=%b want 0", m_axis_tvalid, bram_rden, busy, m_axis_tlast); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL midrst_cmd_ready: got %b want 0", cmd_ready); else n_pass++;
        rst = 1'b0;
        exp_dat.delete(); exp_last.delete();
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1 || m_axis_tvalid !== 1'b0) $display("FAIL midrst_after: got ready=%b tvalid=%b want 1/0", cmd_ready, m_axis_tvalid); else n_pass++;
        m_axis_tready = 1'b1;
        issue_cmd(16'h0100, 16'd1);
        collect(2, 40, 1'b0);
        n_checks++; if (got_dat.size() != 2) $display("FAIL midrst_count: got %0d want 2", got_dat.size()); else n_pass++;
        for (int k = 0; k < got_dat.size(); k++) begin
            n_checks++;
            if (got_dat[k] !== exp_dat[0] || got_last[k] !== exp_last[0]) $display("FAIL midrst_beat%0d: got %h/%b want %h/%b", k, got_dat[k], got_last[k], exp_dat[0], exp_last[0]); else n_pass++;
            void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
        repeat (4) @(negedge clk);
        n_checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_no_extra: got tvalid=%b busy=%b want 0/0", m_axis_tvalid, busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int last_pop;
        acc_q.delete(); exp_dat.delete(); exp_last.delete();
        @(negedge clk);
        m_axis_tready = 1'b1;
        cmd_addr = 16'h0020; cmd_len = 16'd2; cmd_valid = 1'b1;
        push_exp(16'h0020, 16'd2);
        @(negedge clk);
        cmd_addr = 16'h0040; cmd_len = 16'd1;
        push_exp(16'h0040, 16'd1);
        collect(3, 50, 1'b0);
        last_pop = (got_cyc.size() == 3) ? got_cyc[2] : -100;
        n_checks++; if (got_dat.size() != 3 || acc_q.size() != 1) $display("FAIL b2b_first: got beats=%0d accepts=%0d want 3/1", got_dat.size(), acc_q.size()); else n_pass++;
        for (int k = 0; k < got_dat.size(); k++) begin
            n_checks++;
            if (got_dat[k] !== exp_dat[0] || got_last[k] !== exp_last[0]) $display("FAIL b2b_a_beat%0d: got %h want %h", k, got_dat[k], exp_dat[0]); else n_pass++;
            void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
        for (int c = 0; c < 20 && acc_q.size() < 2; c++) begin
            @(negedge clk);
            m_axis_tready = 1'b0;
        end
        cmd_valid = 1'b0;
        n_checks++; if (acc_q.size() != 2) $display("FAIL b2b_second_accept: got %0d accepts want 2", acc_q.size()); else n_pass++;
        if (acc_q.size() == 2) begin
            n_checks++; if (acc_q[1] != last_pop + 2) $display("FAIL b2b_accept_time: got %0d want %0d", acc_q[1], last_pop + 2); else n_pass++;
        end
        collect(2, 40, 1'b0);
        n_checks++; if (got_dat.size() != 2) $display("FAIL b2b_b_count: got %0d want 2", got_dat.size()); else n_pass++;
        for (int k = 0; k < got_dat.size(); k++) begin
            n_checks++;
            if (got_dat[k] !== exp_dat[0] || got_last[k] !== exp_last[0]) $display("FAIL b2b_b_beat%0d: got %h/%b want %h/%b", k, got_dat[k], got_last[k], exp_dat[0], exp_last[0]); else n_pass++;
            void'(exp_dat.pop_front()); void'(exp_last.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_single_word();
        test_wrap();
        test_backpressure();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multi_bank_bram_stream_reader.md
Name: multi_bank_bram_stream_reader

Overview:
Read-side stage placed directly downstream of the multi-bank dual-port BRAM. It accepts a burst command (start address, word count) and drives the read-enable and address on one BRAM port of every bank in lock-step. Each bank returns its word with 1-cycle read latency. The block concatenates the per-bank words into one AXI-Stream beat per address and delivers them with full backpressure support, at 1 beat/cycle sustained and with no combinational path from m_axis_tready to the BRAM.

Parameters:
BANKS, 4, number of BRAM banks read in parallel
DATA_WIDTH, 32, word width per bank
ADDR_WIDTH, 16, per-bank address width

Ports:
clk  input  1  single clock for all logic and the BRAM read port
rst  input  1  synchronous, active-high reset
cmd_addr  input  ADDR_WIDTH  start address of the burst
cmd_len  input  ADDR_WIDTH  burst length minus one (words = cmd_len+1)
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
bram_rden  output  BANKS  read enable per bank; all bits identical
bram_addr  output  BANKS*ADDR_WIDTH  per-bank address; all slices identical
bram_dout  input  BANKS*DATA_WIDTH  BRAM read data, valid the cycle after rden
m_axis_tdata  output  BANKS*DATA_WIDTH  bank i at bits [i*DATA_WIDTH +: DATA_WIDTH]
m_axis_tvalid  output  1  beat valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  high on the final beat of a burst
busy  output  1  high whenever state != IDLE

Behaviour:
- FSM states:
  - IDLE: cmd_ready=1 while rst is low. On accept, latch addr=cmd_addr and remaining=cmd_len, then go to READ.
  - READ: issue reads. After issuing the read with remaining==0, go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty, then go to IDLE.
- cmd_ready is low in READ and DRAIN. Only one burst is outstanding at a time.
- Issue rule: bram_rden = {BANKS{state==READ && (occ + inflight) < 3}}.
  - occ is the occupancy of a 3-entry output FIFO.
  - inflight is the registered previous-cycle rden, 0 or 1.
  - The rule uses registered terms only; it does not depend on m_axis_tready.
- On each issue, addr increments modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000 at ADDR_WIDTH=16) and remaining decrements.
- bram_addr holds its last value when rden is low.
- Capture: when inflight==1, bram_dout is written into the FIFO that cycle, together with a last flag. The last flag is set when that read was the remaining==0 issue.
- Output: m_axis_tvalid = (occ != 0). m_axis_tdata and m_axis_tlast come from the FIFO head.
- Pop occurs on tvalid && tready. A pop and a capture in the same cycle leave occ unchanged.
- The FIFO never overflows, guaranteed by the issue rule.
- Latency: command accepted at edge E0 → rden high in cycle after E0 → data captured at E2 → m_axis_tvalid high after E2. First beat is therefore visible 2 cycles after acceptance.
- Throughput: with tready held high, one beat per cycle (steady state occ=1, inflight=1).
- Backpressure: with tready low, at most 3 words are read. Issuing resumes as pops free credit, and no data is lost or duplicated.
- Max burst: cmd_len = 2^ADDR_WIDTH-1 reads every address once, wrapping back to the start.
- Reset (any cycle, including mid-burst): next cycle state=IDLE, occ=0, inflight=0, bram_rden=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0. bram_addr resets to 0.
  - cmd_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
  - Data returning from a pre-reset read is discarded.

Test Plan:
- Reset, then burst cmd_addr=0x0010, cmd_len=3, tready=1, banks preloaded so bank i at address a holds {i,a} → 4 beats on consecutive cycles. Beat k tdata slice i = {i,0x10+k}; tlast only on beat 3; first tvalid 2 cycles after accept; busy falls 1 cycle after the last pop.
- cmd_len=0 at cmd_addr=0x0005 → exactly one rden pulse and one beat with tlast=1; cmd_ready returns high afterwards.
- Wrap: cmd_addr=0xFFFE, cmd_len=3 → issued addresses FFFE, FFFF, 0000, 0001; data in that order.
- Backpressure: cmd_len=15 with tready=0 for 10 cycles after accept → exactly 3 rden pulses, tvalid stable and tdata stable on beat 0. Then with random tready → 16 beats in order, no gaps or repeats, tlast on beat 15.
- Reset asserted 4 cycles into a cmd_len=15 burst → next cycle tvalid=0, rden=0, busy=0. A new burst cmd_addr=0x0100, cmd_len=1 returns exactly 2 correct beats with no stale data.
- cmd_valid held high during a burst → the second command is accepted only after the first burst's last pop (cmd_ready stays low until IDLE).
